// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the regfile_sweep storage block:
//               sweep FSM state encoding, default geometry and the clog2
//               helper used to size address ports.
// Ports       : none (package)
// Config      : none here; the top honours REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Smallest n with 2**n >= value; used for ADDR_W, so value >= 2 in practice.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sweep_ctrl.sv
// ============================================================================
// Module      : regfile_sweep_ctrl
// Description : Clear sequencer for regfile_sweep. Walks a pointer over every
//               entry after reset or on a clear request, raising busy while it
//               runs, and hands a clear-write strobe plus the pointer to the
//               array logic.
// Ports       : clk_i      - clock, rising edge
//               rst_ni     - synchronous active-low reset
//               clr_req_i  - clear request pulse (ignored while sweeping)
//               busy_o     - sweep in progress (registered)
//               wready_o   - write port may accept, ~busy_o
//               clr_we_o   - zero the entry at ptr_o on this edge
//               ptr_o      - sweep pointer
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              wready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [0:0]        ST_SWEEP = SWEEP;
  localparam logic [0:0]        ST_IDLE  = IDLE;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_SWEEP: begin
        // Clear requests are deliberately not looked at here: a request
        // arriving mid-sweep must not restart the pointer.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign wready_o = ~busy_q;
  // Gated by reset so an edge with reset asserted never touches the array.
  assign clr_we_o = (state_q == ST_SWEEP) && rst_ni;
  assign ptr_o    = ptr_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sweep.sv
// ============================================================================
// Module      : regfile_sweep
// Description : Parametrised register file, one write port and two registered
//               read ports, with an optional hardwired-zero register 0 and a
//               clear sweep that zeroes every entry after reset or on request.
// Ports       : Clk            - clock, rising edge
//               Rst_n          - synchronous active-low reset
//               Clr_req        - request a full clear sweep
//               Busy           - sweep in progress
//               WE/Waddr/Wdata - write port, accepted when Wready is high
//               Wready         - ~Busy
//               Raddr1/Raddr2  - read addresses
//               Dout1/Dout2    - registered read data (1-cycle latency)
// Config      : REGFILE_BYPASS_EN - when defined, a read of the address being
//               written on the same edge returns the new write data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sweep
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clr_req,
  output logic              Busy,
  input  logic              WE,
  output logic              Wready,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [WIDTH-1:0]  Wdata,
  input  logic [ADDR_W-1:0] Raddr1,
  input  logic [ADDR_W-1:0] Raddr2,
  output logic [WIDTH-1:0]  Dout1,
  output logic [WIDTH-1:0]  Dout2
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  // True when the address names a real, writable entry: inside DEPTH and not
  // the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] ptr;
  logic              wr_en;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd1_d, rd2_d;
  logic [WIDTH-1:0]  dout1_q, dout2_q;

  regfile_sweep_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .clr_req_i (Clr_req),
    .busy_o    (busy),
    .wready_o  (Wready),
    .clr_we_o  (clr_we),
    .ptr_o     (ptr)
  );

  // Out-of-range and register-0 writes are still accepted (Wready high) but
  // never reach the array.
  assign wr_en = WE && Wready && Rst_n && addr_live(Waddr);

  // The array has no reset; the sweep is what brings it to a known state.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem_q[ptr] <= '0;
    end else if (wr_en) begin
      mem_q[Waddr] <= Wdata;
    end
  end

  always_comb begin
    rd1_d = addr_live(Raddr1) ? mem_q[Raddr1] : '0;
    rd2_d = addr_live(Raddr2) ? mem_q[Raddr2] : '0;
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes register 0 and invalid addresses, so forwarding
    // cannot leak data onto a read that must return zero.
    if (wr_en && (Waddr == Raddr1)) begin
      rd1_d = Wdata;
    end
    if (wr_en && (Waddr == Raddr2)) begin
      rd2_d = Wdata;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dout1_q <= '0;
      dout2_q <= '0;
    end else if (busy) begin
      dout1_q <= '0;
      dout2_q <= '0;
    end else begin
      dout1_q <= rd1_d;
      dout2_q <= rd2_d;
    end
  end

  assign Busy  = busy;
  assign Dout1 = dout1_q;
  assign Dout2 = dout2_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sweep.sv
// ============================================================================
// Module      : tb_regfile_sweep
// Description : Self-checking bench for regfile_sweep (WIDTH=32, DEPTH=8,
//               ZERO_REG=1). A behavioural model tracks array contents and the
//               remaining sweep length; every clock step compares all outputs.
// Config      : honours REGFILE_BYPASS_EN to match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sweep;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, clr_req, we;
  logic [AW-1:0]    waddr, raddr1, raddr2;
  logic [WIDTH-1:0] wdata;
  logic             busy, wready;
  logic [WIDTH-1:0] dout1, dout2;

  regfile_sweep #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (1)
  ) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Clr_req (clr_req),
    .Busy    (busy),
    .WE      (we),
    .Wready  (wready),
    .Waddr   (waddr),
    .Wdata   (wdata),
    .Raddr1  (raddr1),
    .Raddr2  (raddr2),
    .Dout1   (dout1),
    .Dout2   (dout2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as the spec defines them once a sweep has
  // finished, plus the number of clock edges the current sweep still needs.
  logic [WIDTH-1:0] mmem [DEPTH];
  int               sweep_left = DEPTH;
  logic [WIDTH-1:0] e_d1 = '0, e_d2 = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && we && (waddr == a)) return wdata;
    return mmem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
  endtask

  // Applies one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    if (!rst_n) begin
      sweep_left = DEPTH;
      e_d1 = '0;
      e_d2 = '0;
      model_clear();
    end else if (sweep_left > 0) begin
      sweep_left--;
      e_d1 = '0;
      e_d2 = '0;
    end else begin
      e_d1 = model_read(raddr1);
      e_d2 = model_read(raddr2);
      if (we && (waddr != 0)) mmem[waddr] = wdata;
      if (clr_req) begin
        sweep_left = DEPTH;
        model_clear();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("busy",   {31'd0, busy},   {31'd0, sweep_left > 0});
    check("wready", {31'd0, wready}, {31'd0, sweep_left == 0});
    check("dout1",  dout1, e_d1);
    check("dout2",  dout2, e_d2);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; clr_req = 1'b0; we = 1'b0;
    waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
  endtask

  typedef struct {
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] exp_d1;
    logic [WIDTH-1:0] exp_d2;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    tbl[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 3'd1, 3'd3, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 3'd0, 32'h0,        3'd5, 3'd3, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 3'd0, 32'h12345678, 3'd0, 3'd5, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 3'd0, 32'h0,        3'd0, 3'd0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 3'd2, 32'h11111111, 3'd6, 3'd6, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 3'd2, 32'hA5A5A5A5, 3'd2, 3'd5,
               BYP ? 32'hA5A5A5A5 : 32'h11111111, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 3'd0, 32'h0,        3'd2, 3'd7, 32'hA5A5A5A5, 32'h0};

    // ---- reset sweep ----
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (busy && cnt < 40);
    check("reset_sweep_len", cnt, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(DEPTH - 1 - a);
      step();
      check("post_reset_rd", dout1, 32'h0);
    end

    // ---- table: write/read, zero register, same-cycle read/write ----
    for (int i = 0; i < 7; i++) begin
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      raddr1 = tbl[i].ra1; raddr2 = tbl[i].ra2;
      check("tbl_wready", {31'd0, wready}, 32'd1);
      step();
      check($sformatf("tbl%0d_d1", i), dout1, tbl[i].exp_d1);
      check($sformatf("tbl%0d_d2", i), dout2, tbl[i].exp_d2);
    end
    idle_inputs();

    // ---- clear during traffic ----
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = 32'h100 + i;
      step();
    end
    we = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; waddr = 3'd4; wdata = 32'hCAFEF00D;
    cnt = 0;
    while (busy && cnt < 40) begin
      check("sweep_wready", {31'd0, wready}, 32'd0);
      clr_req = (cnt == 3 || cnt == 6);
      step();
      cnt++;
    end
    clr_req = 1'b0;
    check("clear_sweep_len", cnt, DEPTH);
    check("held_wready", {31'd0, wready}, 32'd1);
    step();
    we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(a);
      step();
      check("after_clear", dout1, (a == 4) ? 32'hCAFEF00D : 32'h0);
    end

    // ---- reset mid-sweep ----
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (busy && cnt < 40);
    check("mid_reset_sweep_len", cnt, DEPTH);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      clr_req = ($urandom_range(0, 24) == 0);
      we      = $urandom_range(0, 1) == 1;
      waddr   = AW'($urandom_range(0, DEPTH - 1));
      wdata   = $urandom;
      raddr1  = AW'($urandom_range(0, DEPTH - 1));
      raddr2  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
